trees_burst_driver: RTL
=======================

// Module: trees_burst_driver
// PURPOSE
// - Host-side initiator for the tree-ensemble ping-pong accelerator.
// - Streams feature words from an input stream into the accelerator feature memory, pulses start, waits for done.
// - Then reads the packed prediction words back and emits them on an output stream, ready for DMA write-back.
// PARAMETERS
// - N_FEATURE       32     features per sample (32-bit each); HALF = N_FEATURE/2 64-bit words per sample
// - MAX_BURST       5000   max samples per burst; BB = $clog2(MAX_BURST)
// - TIMEOUT_CYCLES  2**20  done watchdog limit (used only with TREES_DRV_TIMEOUT_EN)
// PORTS
// - clk              in   1        clock
// - rst_n            in   1        synchronous active-low reset
// - cfg_valid        in   1        burst request
// - cfg_ready        out  1        high only in IDLE
// - cfg_burst_len    in   BB+1     samples in burst
// - in_valid         in   1        feature word valid
// - in_ready         out  1        high only in LOAD
// - in_data          in   64       two packed 32-bit features
// - load_features    out  1        accelerator feature write strobe
// - feature_addr     out  $clog2(MAX_BURST*HALF)   feature word address
// - features2        out  64       feature write data
// - start            out  1        one-cycle burst start pulse
// - burst_len        out  BB+1     latched burst length, held stable until IDLE
// - done             in   1        accelerator one-cycle completion pulse
// - prediction_addr  out  BB+1     prediction word index (combinational read)
// - prediction       in   64       eight 8-bit predictions, byte k = sample 8*w+k
// - out_valid        out  1        prediction word valid
// - out_ready        in   1        downstream accept
// - out_data         out  64       prediction word
// - out_last         out  1        final word of burst
// - busy             out  1        state != IDLE
// - err              out  1        one-cycle timeout pulse
// BEHAVIOUR
// - Reset (sync, rst_n=0 at posedge): state=IDLE, all outputs 0 except cfg_ready=1.
//   Reset mid-burst aborts immediately; the accelerator is re-armed by the next start.
// - IDLE
//   - on cfg_valid: latch L = min(cfg_burst_len, MAX_BURST).
//   - L==0: stay IDLE, no start, no output.
//   - else: -> LOAD, word counter wc=0.
// - LOAD
//   - in_ready=1; each in_valid&&in_ready: load_features=1, feature_addr=wc, features2=in_data (registered, 1-cycle latency), wc++.
//   - after word L*HALF-1 accepted: -> START.
// - START: start=1 for exactly one cycle -> RUN.
// - RUN
//   - wait for done; done sampled only in RUN (ignored in other states).
//   - on done -> READ, rd=0, NW = (L+7)>>3.
// - READ
//   - prediction_addr=rd; word captured into out_data when !out_valid||out_ready.
//   - capture sets out_valid=1 and rd++.
//   - out_last=1 with word NW-1.
//   - last-word mask: bytes k >= (L mod 8) forced to 0 when L mod 8 != 0.
//   - out_valid/out_data hold stable while out_valid&&!out_ready (AXI-style).
//   - back-to-back words at full throughput when out_ready=1.
//   - after last word accepted: -> IDLE (cfg_ready=1 next cycle).
// - Counters: wc width $clog2(MAX_BURST*HALF)+1; no wrap, since L is saturated.
// - cfg_valid while busy is ignored (not queued).
// CONFIGURATION
// - TREES_DRV_TIMEOUT_EN defined
//   - RUN counts cycles; at TIMEOUT_CYCLES without done: err=1 one cycle, -> IDLE, no output words.
// - TREES_DRV_TIMEOUT_EN undefined: no counter, RUN waits indefinitely, err tied 0.
// TESTING
// - L=1, N_FEATURE=32: 16 in words -> 16 writes addr 0..15, one start pulse;
//   done -> one out word, bytes 7..1 zero, out_last=1.
// - L=20: 320 words loaded, start once; done -> 3 out words, third masked to bytes 0..3, out_last on third.
// - L=16 with out_ready toggling 1/0 each cycle: 2 words, out_data stable while stalled, no drop or duplicate.
// - cfg_burst_len=0 -> no load_features, no start, cfg_ready stays 1; cfg_burst_len=6000 -> burst_len=5000.
// - rst_n low for 1 cycle during LOAD at wc=7 -> IDLE, in_ready=0, cfg_ready=1; new burst L=2 completes correctly.
// - TREES_DRV_TIMEOUT_EN, TIMEOUT_CYCLES=100, done never asserted -> err pulse at cycle 100 of RUN, IDLE, out_valid=0.

Source files
------------

// File: rtl/trees_burst_driver.sv
// Host-side burst initiator: streams features into the accelerator, starts it, then drains predictions.
// Optional done watchdog is enabled with TREES_DRV_TIMEOUT_EN.
module trees_burst_driver #(
  parameter int N_FEATURE      = 32,
  parameter int MAX_BURST      = 5000,
  parameter int TIMEOUT_CYCLES = 2**20,
  localparam int HALF = N_FEATURE / 2,
  localparam int BB   = $clog2(MAX_BURST),
  localparam int FA   = $clog2(MAX_BURST * HALF),
  localparam int WCW  = FA + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [BB:0]   cfg_burst_len,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [63:0]   in_data,
  output logic          load_features,
  output logic [FA-1:0] feature_addr,
  output logic [63:0]   features2,
  output logic          start,
  output logic [BB:0]   burst_len,
  input  logic          done,
  output logic [BB:0]   prediction_addr,
  input  logic [63:0]   prediction,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [63:0]   out_data,
  output logic          out_last,
  output logic          busy,
  output logic          err
);
  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, READ} st_t;
  st_t st_q, st_d;

  logic [BB:0]    len_q, nw_q, rd_q, len_sat;
  logic [WCW-1:0] wc_q, total;
  logic [BB+1:0]  nw_round;
  logic           load_q, out_valid_q, out_last_q;
  logic [FA-1:0]  addr_q;
  logic [63:0]    feat_q, out_data_q, pred_m;
  logic           last_w, cap, tmo;

  assign len_sat  = (cfg_burst_len > (BB+1)'(MAX_BURST)) ? (BB+1)'(MAX_BURST) : cfg_burst_len;
  assign total    = WCW'(len_q) * WCW'(HALF);
  assign nw_round = {1'b0, len_q} + (BB+2)'(7);
  assign last_w   = (rd_q == nw_q - (BB+1)'(1));
  assign cap      = (st_q == READ) && (rd_q != nw_q) && (!out_valid_q || out_ready);

  // Zero the unused tail lanes of a partially filled final word.
  always_comb begin
    pred_m = prediction;
    if (last_w && len_q[2:0] != 3'd0)
      for (int k = 0; k < 8; k++)
        if (k >= int'(len_q[2:0])) pred_m[8*k +: 8] = 8'h00;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) st_q <= IDLE;
    else        st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE:  if (cfg_valid && len_sat != '0) st_d = LOAD;
      LOAD:  if (in_valid && wc_q == total - WCW'(1)) st_d = START;
      START: st_d = RUN;
      RUN:   if (done) st_d = READ;
             else if (tmo) st_d = IDLE;
      READ:  if (out_valid_q && out_ready && out_last_q) st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = (st_q == IDLE);
    in_ready  = (st_q == LOAD);
    start     = (st_q == START);
    busy      = (st_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q <= '0; nw_q <= '0; rd_q <= '0; wc_q <= '0;
      load_q <= 1'b0; addr_q <= '0; feat_q <= '0;
      out_valid_q <= 1'b0; out_last_q <= 1'b0; out_data_q <= '0;
    end else begin
      load_q <= 1'b0;
      case (st_q)
        IDLE: begin
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
          wc_q        <= '0;
          if (cfg_valid) len_q <= len_sat;
        end
        LOAD: if (in_valid) begin
          load_q <= 1'b1;
          addr_q <= wc_q[FA-1:0];
          feat_q <= in_data;
          wc_q   <= wc_q + WCW'(1);
        end
        RUN: if (done) begin
          rd_q <= '0;
          nw_q <= (BB+1)'(nw_round >> 3);
        end
        READ: begin
          if (cap) begin
            out_data_q  <= pred_m;
            out_valid_q <= 1'b1;
            out_last_q  <= last_w;
            rd_q        <= rd_q + (BB+1)'(1);
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef TREES_DRV_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] tmr_q;
  logic          err_q;
  assign tmo = (st_q == RUN) && !done && (tmr_q == TW'(TIMEOUT_CYCLES - 1));
  assign err = err_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmr_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= tmo;
      tmr_q <= (st_q == RUN && !done) ? tmr_q + TW'(1) : '0;
    end
  end
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  assign load_features   = load_q;
  assign feature_addr    = addr_q;
  assign features2       = feat_q;
  assign burst_len       = len_q;
  assign prediction_addr = rd_q;
  assign out_valid       = out_valid_q;
  assign out_data        = out_data_q;
  assign out_last        = out_last_q;
endmodule
